// File: rtl/player_key_decoder.sv
// PS/2 scan-code decoder: turns make/break/E0-prefixed byte sequences into level-held movement
// and fire bits. Define WASD_KEYS_EN to also track W/S/A/D as alternate direction keys.
module player_key_decoder #(
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  parameter logic [7:0]  FIRE_CODE      = 8'h29
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] din,
  input  logic       din_valid,
  input  logic       clear_keys,
  output logic       move_up,
  output logic       move_down,
  output logic       move_left,
  output logic       move_right,
  output logic       fire,
  output logic       fire_pulse,
  output logic       seq_error
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT_CYCLES - 1);

  localparam int KUp    = 0;
  localparam int KDown  = 1;
  localparam int KLeft  = 2;
  localparam int KRight = 3;
  localparam int KFire  = 4;
`ifdef WASD_KEYS_EN
  localparam int KW = 5;
  localparam int KS = 6;
  localparam int KA = 7;
  localparam int KD = 8;
  localparam int NumKeys = 9;
`else
  localparam int NumKeys = 5;
`endif

  typedef enum logic [1:0] {StIdle, StExt, StBrk, StExtBrk} state_e;

  state_e              state_q, state_d;
  logic [NumKeys-1:0]  keys_q, keys_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [NumKeys-1:0]  hit_ext, hit_std, key_hit;
  logic [3:0]          dir_d;
  logic                is_err, evt, evt_brk, fire_pulse_d, seq_error_d;

  assign is_err = (din == 8'hAA) || (din == 8'hFC) || (din == 8'h00) || (din == 8'hFF);

  // Extended arrows only match after E0; bare 75 etc. are keypad codes and ignored.
  always_comb begin
    hit_ext = '0;
    hit_std = '0;
    case (din)
      8'h75:   hit_ext[KUp]    = 1'b1;
      8'h72:   hit_ext[KDown]  = 1'b1;
      8'h6B:   hit_ext[KLeft]  = 1'b1;
      8'h74:   hit_ext[KRight] = 1'b1;
      default: ;
    endcase
    if (din == FIRE_CODE) hit_std[KFire] = 1'b1;
`ifdef WASD_KEYS_EN
    case (din)
      8'h1D:   hit_std[KW] = 1'b1;
      8'h1B:   hit_std[KS] = 1'b1;
      8'h1C:   hit_std[KA] = 1'b1;
      8'h23:   hit_std[KD] = 1'b1;
      default: ;
    endcase
`endif
  end

  assign key_hit = (state_q == StExt || state_q == StExtBrk) ? hit_ext : hit_std;

  always_comb begin
    state_d      = state_q;
    keys_d       = keys_q;
    cnt_d        = cnt_q;
    fire_pulse_d = 1'b0;
    seq_error_d  = 1'b0;
    evt          = 1'b0;
    evt_brk      = 1'b0;
    if (clear_keys) begin
      keys_d  = '0;
      state_d = StIdle;
      cnt_d   = '0;
    end else if (din_valid) begin
      cnt_d = '0;
      if (is_err) begin
        keys_d      = '0;
        state_d     = StIdle;
        seq_error_d = 1'b1;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (din == 8'hE0)      state_d = StExt;
            else if (din == 8'hF0) state_d = StBrk;
            else                   evt = 1'b1;
          end
          StExt: begin
            if (din == 8'hF0)      state_d = StExtBrk;
            else if (din != 8'hE0) evt = 1'b1;
          end
          StBrk: begin
            if (din == 8'hE0) state_d = StExt;
            else begin
              evt     = 1'b1;
              evt_brk = 1'b1;
            end
          end
          StExtBrk: begin
            if (din == 8'hE0)      state_d = StExt;
            else if (din != 8'hF0) begin
              evt     = 1'b1;
              evt_brk = 1'b1;
            end
          end
          default: state_d = StIdle;
        endcase
        if (evt) begin
          state_d = StIdle;
          if (evt_brk) begin
            keys_d = keys_q & ~key_hit;
          end else begin
            keys_d       = keys_q | key_hit;
            fire_pulse_d = key_hit[KFire] & ~keys_q[KFire];
          end
        end
      end
    end else if (state_q != StIdle) begin
      // A stalled prefix is abandoned; held keys are left alone.
      if (cnt_q == CntMax) begin
        state_d     = StIdle;
        cnt_d       = '0;
        seq_error_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
`ifdef WASD_KEYS_EN
    dir_d = {keys_d[KUp] | keys_d[KW], keys_d[KDown] | keys_d[KS],
             keys_d[KLeft] | keys_d[KA], keys_d[KRight] | keys_d[KD]};
`else
    dir_d = {keys_d[KUp], keys_d[KDown], keys_d[KLeft], keys_d[KRight]};
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      keys_q     <= '0;
      cnt_q      <= '0;
      move_up    <= 1'b0;
      move_down  <= 1'b0;
      move_left  <= 1'b0;
      move_right <= 1'b0;
      fire       <= 1'b0;
      fire_pulse <= 1'b0;
      seq_error  <= 1'b0;
    end else begin
      state_q    <= state_d;
      keys_q     <= keys_d;
      cnt_q      <= cnt_d;
      move_up    <= dir_d[3];
      move_down  <= dir_d[2];
      move_left  <= dir_d[1];
      move_right <= dir_d[0];
      fire       <= keys_d[KFire];
      fire_pulse <= fire_pulse_d;
      seq_error  <= seq_error_d;
    end
  end

endmodule

// File: tb/tb_player_key_decoder.sv
// Randomized bench for player_key_decoder against a prefix-flag/held-set reference model,
// plus directed sequences with literal expectations.
module tb_player_key_decoder;

  localparam int unsigned T = 100;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] din;
  logic       din_valid;
  logic       clear_keys;
  logic       move_up, move_down, move_left, move_right, fire, fire_pulse, seq_error;

  int checks = 0;
  int errors = 0;

  // Reference model: pending prefix flags, held key set, idle-edge count since last byte.
  bit       m_ext, m_brk;
  bit [8:0] m_keys;
  int       m_wait;
  bit       m_fp, m_se;

  player_key_decoder #(.TIMEOUT_CYCLES(T), .FIRE_CODE(8'h29)) dut (
    .clk        (clk),
    .reset      (reset),
    .din        (din),
    .din_valid  (din_valid),
    .clear_keys (clear_keys),
    .move_up    (move_up),
    .move_down  (move_down),
    .move_left  (move_left),
    .move_right (move_right),
    .fire       (fire),
    .fire_pulse (fire_pulse),
    .seq_error  (seq_error)
  );

  always #5 clk = ~clk;

  function automatic int key_index(input logic [7:0] code, input bit ext);
    if (ext) begin
      case (code)
        8'h75: return 0;
        8'h72: return 1;
        8'h6B: return 2;
        8'h74: return 3;
        default: return -1;
      endcase
    end
    if (code == 8'h29) return 4;
`ifdef WASD_KEYS_EN
    case (code)
      8'h1D: return 5;
      8'h1B: return 6;
      8'h1C: return 7;
      8'h23: return 8;
      default: ;
    endcase
`endif
    return -1;
  endfunction

  function automatic logic [6:0] model_out();
    bit u, d, l, r;
    u = m_keys[0];
    d = m_keys[1];
    l = m_keys[2];
    r = m_keys[3];
`ifdef WASD_KEYS_EN
    u = u | m_keys[5];
    d = d | m_keys[6];
    l = l | m_keys[7];
    r = r | m_keys[8];
`endif
    return {u, d, l, r, m_keys[4], m_fp, m_se};
  endfunction

  task automatic model_step(input bit valid, input logic [7:0] data, input bit clr);
    int idx;
    m_fp = 1'b0;
    m_se = 1'b0;
    if (clr) begin
      m_keys = '0;
      m_ext  = 1'b0;
      m_brk  = 1'b0;
      m_wait = 0;
    end else if (valid) begin
      m_wait = 0;
      if (data == 8'hAA || data == 8'hFC || data == 8'h00 || data == 8'hFF) begin
        m_keys = '0;
        m_ext  = 1'b0;
        m_brk  = 1'b0;
        m_se   = 1'b1;
      end else if (data == 8'hE0) begin
        m_ext = 1'b1;
        m_brk = 1'b0;
      end else if (data == 8'hF0 && !(m_brk && !m_ext)) begin
        m_brk = 1'b1;
      end else begin
        idx = key_index(data, m_ext);
        if (idx >= 0) begin
          if (m_brk) m_keys[idx] = 1'b0;
          else begin
            if (idx == 4 && !m_keys[4]) m_fp = 1'b1;
            m_keys[idx] = 1'b1;
          end
        end
        m_ext = 1'b0;
        m_brk = 1'b0;
      end
    end else if (m_ext || m_brk) begin
      m_wait++;
      if (m_wait == T) begin
        m_ext  = 1'b0;
        m_brk  = 1'b0;
        m_wait = 0;
        m_se   = 1'b1;
      end
    end
  endtask

  task automatic tick(input bit valid, input logic [7:0] data, input bit clr);
    logic [6:0] got, exp;
    @(negedge clk);
    din_valid  = valid;
    din        = data;
    clear_keys = clr;
    model_step(valid, data, clr);
    @(posedge clk);
    #1;
    got = {move_up, move_down, move_left, move_right, fire, fire_pulse, seq_error};
    exp = model_out();
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL outputs @%0t din=%h v=%0b clr=%0b: got %b expected %b (u,d,l,r,f,fp,se)",
               $time, data, valid, clr, got, exp);
    end
    din_valid  = 1'b0;
    clear_keys = 1'b0;
  endtask

  task automatic send(input logic [7:0] data);
    tick(1'b1, data, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 8'h00, 1'b0);
  endtask

  task automatic lit(input string name, input logic actual, input logic expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, actual, expected);
    end
  endtask

  initial begin
    logic [7:0] arrows [4];
    logic [7:0] wasd   [4];
    logic [7:0] errs   [4];
    logic [7:0] b;
    int         r;
    arrows = '{8'h75, 8'h72, 8'h6B, 8'h74};
    wasd   = '{8'h1D, 8'h1B, 8'h1C, 8'h23};
    errs   = '{8'hAA, 8'hFC, 8'h00, 8'hFF};

    reset      = 1'b1;
    din        = 8'h00;
    din_valid  = 1'b0;
    clear_keys = 1'b0;
    m_keys = '0; m_ext = 1'b0; m_brk = 1'b0; m_wait = 0; m_fp = 1'b0; m_se = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    lit("reset_outputs_zero", |{move_up, move_down, move_left, move_right, fire, fire_pulse,
                                seq_error}, 1'b0);
    @(negedge clk);
    reset = 1'b0;

    // Up arrow make then break
    send(8'hE0); send(8'h75);
    lit("up_make", move_up, 1'b1);
    send(8'hE0); send(8'hF0); send(8'h75);
    lit("up_break", move_up, 1'b0);

    // Typematic fire
    send(8'h29);
    lit("fire_first", fire, 1'b1);
    lit("fire_pulse_first", fire_pulse, 1'b1);
    send(8'h29);
    lit("fire_pulse_repeat", fire_pulse, 1'b0);
    send(8'h29);
    send(8'hF0); send(8'h29);
    lit("fire_break", fire, 1'b0);

    // Error code drops held keys
    send(8'hE0); send(8'h6B); send(8'hE0); send(8'h74);
    lit("left_held", move_left, 1'b1);
    lit("right_held", move_right, 1'b1);
    send(8'hAA);
    lit("left_after_bat", move_left, 1'b0);
    lit("seq_error_bat", seq_error, 1'b1);
    idle(1);
    lit("seq_error_one_cycle", seq_error, 1'b0);

    // Prefix timeout at the boundary
    send(8'hE0);
    idle(T - 1);
    lit("no_timeout_early", seq_error, 1'b0);
    idle(1);
    lit("timeout_pulse", seq_error, 1'b1);
    send(8'h75);
    lit("bare_75_ignored", move_up, 1'b0);

    // clear_keys wins over a same-cycle byte
    send(8'hE0); send(8'h72);
    lit("down_held", move_down, 1'b1);
    tick(1'b1, 8'h29, 1'b1);
    lit("clear_down", move_down, 1'b0);
    lit("clear_no_fire", fire, 1'b0);
    lit("clear_no_pulse", fire_pulse, 1'b0);

`ifdef WASD_KEYS_EN
    send(8'h1D);
    send(8'hE0); send(8'h75);
    send(8'hF0); send(8'h1D);
    lit("wasd_up_still_held", move_up, 1'b1);
    send(8'hE0); send(8'hF0); send(8'h75);
    lit("wasd_up_released", move_up, 1'b0);
`endif

    // Randomized byte stream
    for (int n = 0; n < 1500; n++) begin
      r = $urandom_range(0, 99);
      if (r < 20)      b = 8'hE0;
      else if (r < 35) b = 8'hF0;
      else if (r < 50) b = arrows[$urandom_range(0, 3)];
      else if (r < 60) b = 8'h29;
      else if (r < 70) b = wasd[$urandom_range(0, 3)];
      else if (r < 73) b = errs[$urandom_range(0, 3)];
      else if (r < 75) b = 8'hE1;
      else             b = 8'($urandom_range(0, 255));
      tick(1'b1, b, ($urandom_range(0, 49) == 0));
      if ($urandom_range(0, 19) == 0) idle($urandom_range(T - 3, T + 2));
      else idle($urandom_range(0, 3));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/player_key_decoder.md
Name: player_key_decoder

Overview:
- Converts the scan-code byte stream from the PS/2 byte receiver into the level-held movement and fire signals consumed by the player movement block.
- Each output is high while its key is held. Make, break and extended-prefix sequences are decoded by a small FSM.
- Sits between the keyboard byte receiver and the player movement and shot logic, in the clk domain.

Parameters:
- TIMEOUT_CYCLES, 1000000, number of clk cycles a prefix state may wait for its next byte before the FSM aborts to IDLE (20 ms at 50 MHz).
- FIRE_CODE, 8'h29, non-extended scan code for fire (space bar).

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- din  input  8  scan-code byte from the byte receiver
- din_valid  input  1  one-cycle strobe; din is valid when high
- clear_keys  input  1  synchronous clear of all held keys and the FSM (e.g. on game restart)
- move_up  output  1  up arrow held
- move_down  output  1  down arrow held
- move_left  output  1  left arrow held
- move_right  output  1  right arrow held
- fire  output  1  fire key held
- fire_pulse  output  1  one-cycle pulse on fire key press (make while not already held)
- seq_error  output  1  one-cycle pulse on a timeout abort or a keyboard error/BAT code

Behaviour:
- Reset (async, active-high): all outputs 0, FSM in IDLE, timeout counter 0. All outputs are registered.
- FSM states:
  - IDLE
  - EXT (E0 seen)
  - BRK (F0 seen)
  - EXT_BRK (E0 then F0 seen)
- Transitions, evaluated only on din_valid:
  - IDLE: E0 -> EXT; F0 -> BRK; other codes -> make event (non-extended), stay IDLE.
  - EXT: F0 -> EXT_BRK; E0 -> stay EXT; other codes -> make event (extended), -> IDLE.
  - BRK: E0 -> EXT (discard break, treat as new extended prefix); other codes -> break event (non-extended), -> IDLE.
  - EXT_BRK: E0 -> EXT; F0 -> stay EXT_BRK; other codes -> break event (extended), -> IDLE.
- Key map:
  - Extended: 75 up, 72 down, 6B left, 74 right.
  - Non-extended: FIRE_CODE -> fire.
  - Make sets the key bit; break clears it. Unmapped codes are consumed with no output change. An extended code's value in non-extended context is not a match (e.g. bare 75 is keypad 8 and is ignored).
- fire_pulse: high for exactly one cycle when a fire make arrives while fire=0. Typematic repeats (fire already 1) produce no pulse.
- Error codes: AA (BAT), FC, 00 and FF received in any state clear all held keys, pulse seq_error and force IDLE.
- Timeout:
  - The counter runs in non-IDLE states and resets on every din_valid and on entry to IDLE.
  - Reaching TIMEOUT_CYCLES-1 forces IDLE and pulses seq_error; held keys are unchanged.
  - Counter width is $clog2(TIMEOUT_CYCLES)+1.
- Latency: din_valid at cycle N -> move_*/fire/fire_pulse change at cycle N+1.
- clear_keys:
  - Takes priority over din_valid in the same cycle: all held bits 0, FSM IDLE, no fire_pulse, byte dropped.
  - Does not pulse seq_error.
- Opposite directions may be held simultaneously. Resolving them is the consumer's job; this block reports raw key state.
- E1 (Pause) sequences pass through as unmapped bytes with no effect.

Optional Feature:
- Macro: WASD_KEYS_EN
- Defined: non-extended W(1D), S(1B), A(1C), D(23) are tracked as four additional held bits. move_up = up_arrow | w, and likewise for the other three directions. A direction output clears only when both of its keys are released.
- Undefined: 1D/1B/1C/23 are treated as unmapped, and the extra state does not exist.

Test Plan:
- Send E0,75 -> move_up=1 one cycle after the 75 strobe. Then send E0,F0,75 -> move_up=0; all other outputs remain 0 throughout.
- Send 29 three times (typematic), then F0,29 -> fire=1 after the first byte; fire_pulse exactly one cycle, only after the first 29; fire=0 after the final 29.
- Hold left (E0,6B) and right (E0,74), then send AA -> both 1, then both 0 one cycle after AA, with seq_error one cycle.
- Send E0 then wait TIMEOUT_CYCLES (set to 100) -> seq_error pulse at the 100th cycle, FSM IDLE. A following 75 does not set move_up.
- Assert clear_keys in the same cycle as din_valid with din=29 while move_down=1 -> all outputs 0, no fire_pulse.
- With WASD_KEYS_EN: send 1D and E0,75, then F0,1D -> move_up stays 1. Then send E0,F0,75 -> move_up=0.
